// File: rtl/des_block_unloader.sv
// des_block_unloader: buffers 64-bit DES output blocks in a small FIFO
// and serialises each one MSB-first over a byte-wide valid/ready port.
module des_block_unloader #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        blk_valid,
  input  logic [31:0]                 leftIn,
  input  logic [31:0]                 rightIn,
  output logic                        blk_ready,
  output logic [7:0]                  byte_data,
  output logic                        byte_valid,
  input  logic                        byte_ready,
  output logic [$clog2(FIFO_DEPTH):0] fill_level,
  output logic                        busy,
  output logic                        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q;
  logic [63:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [63:0]     shreg_q;
  logic [2:0]      cnt_q;
  logic            ovf_q, ovf_d;

  logic has_blk;
  logic last_xfer;
  logic pop;
  logic push;

  assign has_blk   = (count_q != '0);
  assign last_xfer = (state_q == SEND) && byte_ready
                   && (cnt_q == 3'd7);
  // Refill from the FIFO when idle or as the 8th byte leaves.
  assign pop       = has_blk && ((state_q == IDLE) || last_xfer);
  assign blk_ready = (count_q < FULL_C) || pop;
  assign push      = blk_valid && blk_ready;

  assign byte_valid = (state_q == SEND);
  assign byte_data  = shreg_q[63:56];
  assign fill_level = count_q;
  assign busy       = (state_q != IDLE) || has_blk;
  assign overflow   = ovf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (blk_valid && !blk_ready) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {leftIn, rightIn};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            shreg_q <= mem_q[rd_ptr_q];
            cnt_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (byte_ready) begin
            cnt_q <= cnt_q + 3'd1;
            if (pop) begin
              shreg_q <= mem_q[rd_ptr_q];
            end else begin
              shreg_q <= {shreg_q[55:0], 8'h00};
              if (cnt_q == 3'd7) state_q <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/des_block_unloader.md
DES_BLOCK_UNLOADER -- requirements
Module: des_block_unloader

Interface
REQ-001: Parameter FIFO_DEPTH, default 4, SHALL set the number of buffered 64-bit blocks; it SHALL be a power of two and at least 2.
REQ-002: clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-003: rst  input  1  asynchronous, active-high reset.
REQ-004: blk_valid  input  1  the final DES pipeline stage presents a valid block this cycle.
REQ-005: leftIn  input  32  left half of the final-stage block.
REQ-006: rightIn  input  32  right half of the final-stage block.
REQ-007: blk_ready  output  1  high when a block offered this cycle will be accepted; informational only, because the pipeline does not stall.
REQ-008: byte_data  output  8  serial-side byte.
REQ-009: byte_valid  output  1  byte_data is valid.
REQ-010: byte_ready  input  1  the downstream UART transmitter accepts the byte.
REQ-011: fill_level  output  $clog2(FIFO_DEPTH)+1  number of blocks currently buffered, excluding the block in the shift register.
REQ-012: busy  output  1  high when state != IDLE or fill_level != 0.
REQ-013: overflow  output  1  sticky flag indicating a block was dropped.

Function
REQ-014: Capture: on posedge clk with blk_valid=1 and blk_ready=1, the block SHALL be pushed as the 64-bit word {leftIn, rightIn}.
REQ-015: blk_ready SHALL equal (fill_level < FIFO_DEPTH) OR (a pop occurs this cycle).
- A push and a pop in the same cycle when full SHALL both succeed, and fill_level SHALL stay at FIFO_DEPTH.
REQ-016: A push while blk_ready=0 SHALL be discarded and SHALL set overflow=1.
- overflow SHALL be cleared only by rst.
- Buffered contents and fill_level SHALL be unaffected by a discarded push.
REQ-017: The FIFO SHALL be a circular buffer with read and write pointers that wrap modulo FIFO_DEPTH; ordering SHALL be strict FIFO.
REQ-018: The FSM SHALL have exactly two states, IDLE and SEND.
REQ-019: IDLE behaviour:
- byte_valid=0.
- If fill_level != 0: pop the head into a 64-bit shift register, clear the 3-bit byte counter, and go to SEND on the next edge.
REQ-020: SEND behaviour:
- byte_valid=1.
- byte_data SHALL equal shift register bits [63:56], so bytes go out MSB first: leftIn[31:24] first and rightIn[7:0] last.
REQ-021: Handshake: a byte SHALL transfer only on an edge where byte_valid=1 and byte_ready=1.
- While byte_ready=0, byte_data and byte_valid SHALL hold stable.
- Dropping byte_valid before the transfer is prohibited.
REQ-022: On each transfer the shift register SHALL shift left by 8 and the byte counter SHALL increment.
REQ-023: On the transfer of the 8th byte (counter=7):
- If fill_level != 0, the next block SHALL be popped and loaded in the same edge, the state SHALL remain SEND, and byte_valid SHALL stay high with no gap cycle.
- Otherwise the state SHALL go to IDLE.
REQ-024: Latency: a block captured at edge t into an empty, idle unit SHALL present its first byte with byte_valid=1 after edge t+1.
REQ-025: Throughput: with byte_ready held at 1, one 64-bit block SHALL leave every 8 cycles, with no bubbles between blocks.
REQ-026: byte_ready asserted while in IDLE SHALL be ignored.

Reset
REQ-027: While rst=1, regardless of clk, the following SHALL hold:
- state=IDLE, FIFO pointers=0, fill_level=0, byte counter=0, shift register=0.
- byte_valid=0, byte_data=0x00, overflow=0, busy=0, blk_ready=1.
REQ-028: Reset asserted mid-block SHALL discard the partial block and all buffered blocks.
- No byte SHALL be emitted until a new block is captured after rst deasserts.
REQ-029: The first capture SHALL be possible on the first posedge clk after rst deasserts.

Verification
REQ-030: Single block, left=0x01234567, right=0x89ABCDEF, byte_ready=1 -> bytes 01 23 45 67 89 AB CD EF on 8 consecutive edges, first byte_valid after capture edge+1, then IDLE and busy=0.
REQ-031: Same block with byte_ready toggling 1,0,0,1,... -> identical byte sequence, byte_data stable during every byte_ready=0 cycle, no byte lost or duplicated.
REQ-032: FIFO_DEPTH=4, byte_ready=0, 6 back-to-back blocks -> first block in the shift register, 4 blocks buffered, 6th dropped, fill_level=4, overflow=1. After releasing byte_ready -> 40 bytes out in order, overflow stays 1.
REQ-033: Full FIFO with push coinciding with the 8th-byte pop -> push accepted, overflow unchanged, fill_level stays 4.
REQ-034: Continuous blocks every 8 cycles with byte_ready=1 -> byte_valid never drops, and pointer wrap-around passes with correct ordering over at least 3 FIFO wraps.
REQ-035: rst pulsed during the 4th byte with 2 blocks buffered -> byte_valid=0, fill_level=0, busy=0 immediately. After release, a new block 0xFFFFFFFF_00000000 -> FF FF FF FF 00 00 00 00 only.
